uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

Serial receive stage paired with the LED-counter UART transmitter: it consumes the 8N1 stream that the tx line produces, or an external host drives it, and recovers bytes. It synchronises the asynchronous rx pin, detects and qualifies the start bit, and samples each bit at its centre. Completed bytes are presented on a valid/ready output register so a downstream consumer, such as the LED or nibble display logic, can accept them at its own pace. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 104; clock cycles per UART bit. Must be ≥ 4. Bench uses 8.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous active-low reset. Applies to every flop.
- `rx` input 1: serial line. Asynchronous to `clk`; idle level is 1.
- `rx_data` output 8: received byte. Reset value 0x00.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte. Reset value 0.
- `rx_ready` input 1: consumer accepts `rx_data` when `rx_valid && rx_ready` on a rising edge.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled 0. Reset value 0.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the output register is full. Reset value 0.
- `busy` output 1: FSM is not in IDLE. Reset value 0.

## Operation
- The synchroniser is two flops, both resetting to 1. Its output is `rx_s`.
- FSM states are IDLE, START, DATA, PARITY (macro only), STOP. Reset state is IDLE.
- The bit counter `cnt` has width `$clog2(CLKS_PER_BIT)`. The bit index `idx` is 3 bits.
- IDLE
  - If `armed && rx_s==0`: go to START, clear `cnt`.
  - `armed` sets when `rx_s==1` and clears on leaving IDLE. It resets to 1.
- START
  - When `cnt == CLKS_PER_BIT/2 - 1`, sample `rx_s`.
  - If the sample is 1 (glitch): go to IDLE. No flags.
  - Otherwise go to DATA with `cnt=0`, `idx=0`.
- DATA
  - Sample when `cnt == CLKS_PER_BIT-1`, then clear `cnt`.
  - Shift bits in LSB first.
  - After `idx==7`, go to STOP, or to PARITY if compiled in.
- STOP
  - Sample when `cnt == CLKS_PER_BIT-1`, then return to IDLE. Do not wait for the bit end, so the next start bit is caught.
  - Sample 1 (and parity ok): byte is good.
  - Sample 0: pulse `frame_err` and discard the byte. Because `armed` is clear, a held-low line (break) does not retrigger until rx returns high.
- Output register for a good byte:
  - If `!rx_valid`, or `rx_valid && rx_ready` in the same cycle: load `rx_data` and set `rx_valid`. A simultaneous consume and load keeps `rx_valid` at 1.
  - If `rx_valid && !rx_ready`: keep the old byte and pulse `overrun`.
- `rx_valid` clears on a handshake when no new byte loads in that cycle.
- `rx_data` holds its value after it is consumed.
- Reset asserted mid-frame aborts the frame. All outputs return to their reset values immediately; no partial byte survives.

## Timing
- Let edge 0 be the first rising edge at which the `rx` pin is low, and H = `CLKS_PER_BIT/2` (integer division). C = `CLKS_PER_BIT`.
- Start bit sampled at edge 2+H.
- Data bit i sampled at edge 2+H+(i+1)·C.
- Stop bit sampled at edge 2+H+9·C. `rx_valid`, `frame_err` and `overrun` are registered at that edge. PARITY adds C.
- Back-to-back frames are accepted with zero idle bits between stop and the next start.
- Tolerated baud mismatch is about ±4% at C ≥ 8.
- `busy` is high from edge 2 until the stop-bit sample edge.

## Configuration
- `UART_RX_PARITY_EN`
- Defined:
  - The PARITY state samples one even-parity bit after bit 7.
  - A mismatch is treated exactly like a framing error: `frame_err` pulses and the byte is discarded.
  - Frame is 8E1; the stop sample moves to 2+H+10·C.
- Undefined: 8N1. The PARITY state and its logic are absent.

## Structure
- Package `uart_pkg`:
  - FSM state enum `rx_state_t`.
  - Frame constant `UART_DATA_BITS = 8`.
  - Helper function for the counter width.
- Sub-module `uart_rx_sync`: two-flop synchroniser with a reset-to-1 parameter. Instantiated once.
- The rest is one module: FSM, counters, shift register and output register.

## Test plan
All scenarios run with C=8.
- Send 0xA5 (8N1), `rx_ready=1`: `rx_valid` pulses one cycle at edge 2+4+72, `rx_data`=0xA5, no flags.
- Send 0x3C with `rx_ready=0`, then 0xC3: first byte held, `overrun` pulses at the second stop sample, `rx_data` stays 0x3C. Raising `rx_ready` then clears `rx_valid`.
- Drive 0x55 with the stop bit forced 0: `frame_err` pulses, `rx_valid` stays 0. Holding rx low for 30 bits produces no further frames; releasing it and sending 0x01 receives 0x01.
- Apply a 2-cycle low glitch on idle rx: FSM returns to IDLE at the start sample, no outputs change.
- Assert `rst_n`=0 at data bit 4 of a frame: all outputs are 0 immediately. After release, the next full frame 0x7E is received correctly.
- With `UART_RX_PARITY_EN` defined: 0x03 sent with parity 0 is accepted; the same frame with parity 1 gives a `frame_err` pulse and no `rx_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// With UART_RX_PARITY_EN defined, the enum also carries the parity state.
package uart_pkg;

  // Number of payload bits per frame
  localparam int UART_DATA_BITS = 8;

  // Receive FSM states
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

  // Width of a counter that must reach clks-1
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// RESET_VAL sets the value both flops reset to, so an idle line reads idle
// straight out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; only q is used by downstream logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver: synchronises rx, qualifies the start bit at its centre,
// samples data bits LSB first and hands complete bytes to a valid/ready
// output register. Framing errors and overruns are one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (even parity
// checked after bit 7; a parity mismatch is reported as a framing error).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int              CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             armed;
  logic             stop_hit;
  logic             byte_good;
`ifdef UART_RX_PARITY_EN
  logic             par_err;
`endif

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Stop-bit sample point and whether the finished frame is acceptable
  always_comb begin
    stop_hit = (state == RX_STOP) && (cnt == CNT_LAST);
`ifdef UART_RX_PARITY_EN
    byte_good = stop_hit && rx_s && !par_err;
`else
    byte_good = stop_hit && rx_s;
`endif
  end

  assign busy = (state != RX_IDLE);

  // Frame FSM: bit timing, start qualification and data shift register.
  // The stop bit is only sampled at its centre and the FSM returns to IDLE
  // immediately, leaving half a bit to catch a back-to-back start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      armed   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      case (state)
        RX_IDLE: begin
          // armed blocks a held-low line (break) from retriggering
          if (armed && !rx_s) begin
            state <= RX_START;
            cnt   <= '0;
            armed <= 1'b0;
          end else if (rx_s) begin
            armed <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            if (rx_s) begin
              state <= RX_IDLE;          // glitch, not a start bit
            end else begin
              state <= RX_DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_err <= rx_s ^ (^shreg);  // even parity over data + parity bit
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            state <= RX_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RX_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output register and status pulses. A consume in the same cycle as a new
  // byte frees the slot, so the new byte loads and rx_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_hit && !byte_good;
      overrun   <= byte_good && rx_valid && !rx_ready;
      if (byte_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboarded bench for uart_rx_byte with CLKS_PER_BIT = 8.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx_byte;

  localparam int C = 8;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 2 + H + 10 * C;
`else
  localparam int STOP_EDGE = 2 + H + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_DATA = 0, EV_FERR = 1, EV_OVR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic pop_check(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=%0d expected=none (t=%0t)", int'(k), $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(int'(k)), 32'(int'(e.kind)));
      if (k == EV_DATA) check("event_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: every DUT-presented event is matched against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)            pop_check(EV_FERR, 8'h00);
      if (overrun)              pop_check(EV_OVR, 8'h00);
      if (rx_valid && rx_ready) pop_check(EV_DATA, rx_data);
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * C) @(posedge clk);
    #1;
  endtask

  // Park on the negedge following edge e
  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout actual=running expected=finished");
    summary();
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_bits(2);

    // 1: single byte, consumer ready, exact latency
    rx_ready = 1'b1;
    push(EV_DATA, 8'hA5);
    t0 = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_edge(t0 + 1);
        check("busy_edge1", 32'(busy), 0);
        wait_edge(t0 + 2);
        check("busy_edge2", 32'(busy), 1);
        wait_edge(t0 + STOP_EDGE - 1);
        check("valid_before_stop", 32'(rx_valid), 0);
        wait_edge(t0 + STOP_EDGE);
        check("valid_at_stop", 32'(rx_valid), 1);
        check("data_at_stop", 32'(rx_data), 32'hA5);
        check("busy_at_stop", 32'(busy), 0);
        wait_edge(t0 + STOP_EDGE + 1);
        check("valid_after_consume", 32'(rx_valid), 0);
      end
    join
    idle_bits(1);

    // 2: overrun with back-to-back frames, old byte held
    rx_ready = 1'b0;
    push(EV_OVR, 8'h00);
    push(EV_DATA, 8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    check("ovr_valid_held", 32'(rx_valid), 1);
    check("ovr_data_held", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_valid_cleared", 32'(rx_valid), 0);
    idle_bits(1);

    // 3: framing error, then a break that must not retrigger
    push(EV_FERR, 8'h00);
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (30 * C) @(posedge clk);
    #1;
    check("break_valid", 32'(rx_valid), 0);
    check("break_busy", 32'(busy), 0);
    idle_bits(2);
    push(EV_DATA, 8'h01);
    send_frame(8'h01, 1'b1);
    idle_bits(1);

    // 4: 2-cycle low glitch is rejected at the start sample
    t0 = cyc + 1;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    wait_edge(t0 + 2 + H - 1);
    check("glitch_busy_start", 32'(busy), 1);
    wait_edge(t0 + 2 + H);
    check("glitch_busy_idle", 32'(busy), 0);
    check("glitch_valid", 32'(rx_valid), 0);
    idle_bits(2);

    // 5: reset during data bit 4 clears everything, next frame is clean
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    check("pre_rst_valid", 32'(rx_valid), 1);
    t0 = cyc + 1;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        wait_edge(t0 + 2 + H + 4 * C + 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_data", 32'(rx_data), 32'h00);
        check("mid_rst_rx_valid", 32'(rx_valid), 0);
        check("mid_rst_frame_err", 32'(frame_err), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_busy", 32'(busy), 0);
      end
    join
    idle_bits(1);
    rst_n = 1'b1;
    idle_bits(2);
    rx_ready = 1'b1;
    push(EV_DATA, 8'h7E);
    send_frame(8'h7E, 1'b1);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    // 6: parity accepted, then parity mismatch reported as framing error
    push(EV_DATA, 8'h03);
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1);
    idle_bits(1);
    push(EV_FERR, 8'h00);
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1);
    par_flip = 1'b0;
    idle_bits(1);
    check("par_err_valid", 32'(rx_valid), 0);
`endif

    repeat (20) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    summary();
    $finish;
  end

endmodule
